digit_sequencer: RTL and testbench

- Upstream stage of the 7-segment digit decoder. Produces the 4-bit digit value that the decoder consumes.
- Steps a single decimal digit (0..MAX_DIGIT) at a prescaled rate, counting up or down.
- Run/pause is toggled by a debounced push-button. The digit can be loaded directly.
- The output is guaranteed never to leave the legal digit range. The downstream decoder has no valid segment pattern for codes above 9.

---
 rtl/digit_sequencer.sv | 177 +++++++++++++++++
 tb/tb_digit_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_sequencer.sv
// Single-digit up/down sequencer feeding the 7-segment decoder.
// A debounced button toggles run/pause; a direct load bypasses stepping.
module digit_sequencer #(
    parameter int TICK_DIV        = 2500000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_DIGIT       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] number,
    output logic       tick,
    output logic       running
);

    localparam int SYNC_STAGES = 2;
    localparam int PRESC_W     = $clog2(TICK_DIV);
    localparam int DB_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]         DIGIT_MAX  = 4'(MAX_DIGIT);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_d;
            if (gi == 0) begin : g_first
                assign stage_d = btn_run;
            end else begin : g_rest
                assign stage_d = sync_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= stage_d;
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debouncer: level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_reg,   db_cnt_next;
    logic            db_level_reg, db_level_next;
    logic            db_differs;
    logic            db_accept;
    logic            press;

    assign db_differs = (sync_out != db_level_reg);
    assign db_accept  = db_differs && (db_cnt_reg == DB_LAST);
    // Press fires on the same edge the debounced level rises.
    assign press      = db_accept && sync_out;

    always_comb begin
        db_cnt_next   = '0;
        db_level_next = db_level_reg;
        if (db_differs) begin
            if (db_accept) begin
                db_level_next = sync_out;
            end else begin
                db_cnt_next = db_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b0;
        end else begin
            db_cnt_reg   <= db_cnt_next;
            db_level_reg <= db_level_next;
        end
    end

    // ------------------------------------------------------------------
    // Run/pause FSM
    // ------------------------------------------------------------------
    state_t state_reg, state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= STOPPED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (press) begin
            state_next = (state_reg == RUNNING) ? STOPPED : RUNNING;
        end
    end

    always_comb begin
        running = (state_reg == RUNNING);
    end

    // ------------------------------------------------------------------
    // Prescaler, digit register and tick
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_reg,  presc_next;
    logic [3:0]         number_reg, number_next;
    logic               tick_reg,   tick_next;
    logic               step_now;
    logic               load_ok;
    logic [3:0]         stepped;

    assign step_now = (state_reg == RUNNING) && (presc_reg == PRESC_LAST);
    assign load_ok  = load && (load_val <= DIGIT_MAX);

    // Wrap checks use >= / > so an out-of-range value could never persist.
    always_comb begin
        if (dir) begin
            stepped = (number_reg >= DIGIT_MAX) ? 4'd0 : number_reg + 4'd1;
        end else begin
            stepped = ((number_reg == 4'd0) || (number_reg > DIGIT_MAX)) ?
                      DIGIT_MAX : number_reg - 4'd1;
        end
    end

    always_comb begin
        presc_next  = presc_reg;
        number_next = number_reg;
        tick_next   = 1'b0;
        if (load_ok) begin
            presc_next  = '0;
            number_next = load_val;
        end else if (state_reg == RUNNING) begin
            if (step_now) begin
                presc_next  = '0;
                number_next = stepped;
                tick_next   = 1'b1;
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg  <= '0;
            number_reg <= 4'd0;
            tick_reg   <= 1'b0;
        end else begin
            presc_reg  <= presc_next;
            number_reg <= number_next;
            tick_reg   <= tick_next;
        end
    end

    assign number = number_reg;
    assign tick   = tick_reg;

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_digit_sequencer;

    logic       clk;
    logic       rst;
    logic       btn_run;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] number;
    logic       tick;
    logic       running;

    int pass_cnt  = 0;
    int total_cnt = 0;

    digit_sequencer #(
        .TICK_DIV       (4),
        .DEBOUNCE_CYCLES(3),
        .MAX_DIGIT      (9)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_run (btn_run),
        .dir     (dir),
        .load    (load),
        .load_val(load_val),
        .number  (number),
        .tick    (tick),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1; btn_run = 1'b0; dir = 1'b1; load = 1'b0; load_val = 4'd0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (number !== 4'd0 || tick !== 1'b0 || running !== 1'b0)
            $display("FAIL reset_state: number=%0d tick=%0b running=%0b, expected 0/0/0",
                     number, tick, running);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (number !== 4'd0 || running !== 1'b0)
            $display("FAIL after_reset: number=%0d running=%0b, expected 0/0", number, running);
        else pass_cnt++;
        $display("reset: number=%0d tick=%0b running=%0b", number, tick, running);
    endtask

    // Press latency: synchronized edge after 2 clocks, accepted 3 clocks later.
    task automatic test_count_up();
        btn_run = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (running !== 1'b0) $display("FAIL run_early: running=%0b expected 0", running);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (running !== 1'b1) $display("FAIL run_on_press: running=%0b expected 1", running);
        else pass_cnt++;
        btn_run = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                total_cnt++;
                if (tick !== 1'b0) $display("FAIL tick_gap: tick=%0b expected 0 (step %0d)", tick, k);
                else pass_cnt++;
            end
            @(negedge clk);
            total_cnt++;
            if (tick !== 1'b1 || number !== 4'(k % 10))
                $display("FAIL count_up: tick=%0b number=%0d expected tick=1 number=%0d",
                         tick, number, k % 10);
            else pass_cnt++;
            $display("count_up step %0d: number=%0d", k, number);
        end
    endtask

    task automatic test_count_down();
        int exp_dn [2] = '{9, 8};
        dir = 1'b0;
        for (int k = 0; k < 2; k++) begin
            repeat (3) @(negedge clk);
            @(negedge clk);
            total_cnt++;
            if (tick !== 1'b1 || number !== 4'(exp_dn[k]))
                $display("FAIL count_down: tick=%0b number=%0d expected tick=1 number=%0d",
                         tick, number, exp_dn[k]);
            else pass_cnt++;
            $display("count_down: number=%0d", number);
        end
        dir = 1'b1;
    endtask

    task automatic test_load();
        repeat (3) @(negedge clk);
        load = 1'b1; load_val = 4'd7;
        @(negedge clk);
        load = 1'b0;
        total_cnt++;
        if (number !== 4'd7 || tick !== 1'b0)
            $display("FAIL load_at_terminal: number=%0d tick=%0b expected 7/0", number, tick);
        else pass_cnt++;
        $display("load 7: number=%0d tick=%0b", number, tick);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total_cnt++;
            if (tick !== 1'b0) $display("FAIL load_gap: tick=%0b expected 0", tick);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (tick !== 1'b1 || number !== 4'd8)
            $display("FAIL after_load_step: tick=%0b number=%0d expected 1/8", tick, number);
        else pass_cnt++;
        load = 1'b1; load_val = 4'd12;
        @(negedge clk);
        load = 1'b0;
        total_cnt++;
        if (number !== 4'd8 || tick !== 1'b0)
            $display("FAIL load_oor_ignored: number=%0d tick=%0b expected 8/0", number, tick);
        else pass_cnt++;
        $display("load 12: number=%0d", number);
        repeat (2) @(negedge clk);
        load = 1'b1; load_val = 4'd12;
        @(negedge clk);
        load = 1'b0;
        total_cnt++;
        if (number !== 4'd9 || tick !== 1'b1)
            $display("FAIL load_oor_step: number=%0d tick=%0b expected 9/1", number, tick);
        else pass_cnt++;
        $display("load 12 at terminal: number=%0d tick=%0b", number, tick);
    endtask

    // Pause lands with the prescaler at 2; resume must tick after 2 cycles.
    task automatic test_pause();
        @(negedge clk);
        btn_run = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (running !== 1'b1) $display("FAIL pause_pre: running=%0b expected 1", running);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (tick !== 1'b1 || number !== 4'd0)
            $display("FAIL wrap_up: tick=%0b number=%0d expected 1/0", tick, number);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (running !== 1'b0) $display("FAIL pause: running=%0b expected 0", running);
        else pass_cnt++;
        btn_run = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            total_cnt++;
            if (tick !== 1'b0 || number !== 4'd0)
                $display("FAIL paused_hold: tick=%0b number=%0d expected 0/0", tick, number);
            else pass_cnt++;
        end
        btn_run = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (running !== 1'b1 || tick !== 1'b0)
            $display("FAIL resume: running=%0b tick=%0b expected 1/0", running, tick);
        else pass_cnt++;
        btn_run = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (tick !== 1'b0) $display("FAIL resume_gap: tick=%0b expected 0", tick);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (tick !== 1'b1 || number !== 4'd1)
            $display("FAIL resume_tick: tick=%0b number=%0d expected 1/1", tick, number);
        else pass_cnt++;
        $display("resume: first tick number=%0d", number);
    endtask

    task automatic test_bounce();
        for (int p = 0; p < 4; p++) begin
            btn_run = 1'b1;
            repeat (2) @(negedge clk);
            btn_run = 1'b0;
            repeat (2) @(negedge clk);
            total_cnt++;
            if (running !== 1'b1) $display("FAIL bounce_reject: running=%0b expected 1 (pulse %0d)", running, p);
            else pass_cnt++;
        end
        repeat (4) @(negedge clk);
        btn_run = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (running !== 1'b1) $display("FAIL held_early: running=%0b expected 1", running);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (running !== 1'b0) $display("FAIL held_toggle: running=%0b expected 0", running);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (running !== 1'b0) $display("FAIL held_once: running=%0b expected 0", running);
        else pass_cnt++;
        btn_run = 1'b0;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (running !== 1'b0) $display("FAIL release_no_toggle: running=%0b expected 0", running);
        else pass_cnt++;
        $display("bounce: running=%0b", running);
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_val = 4'd5;
        @(negedge clk);
        load = 1'b0;
        btn_run = 1'b1;
        repeat (5) @(negedge clk);
        btn_run = 1'b0;
        total_cnt++;
        if (running !== 1'b1 || number !== 4'd5)
            $display("FAIL pre_reset: running=%0b number=%0d expected 1/5", running, number);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (number !== 4'd0 || running !== 1'b0 || tick !== 1'b0)
            $display("FAIL mid_reset: number=%0d running=%0b tick=%0b expected 0/0/0",
                     number, running, tick);
        else pass_cnt++;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            total_cnt++;
            if (tick !== 1'b0 || running !== 1'b0)
                $display("FAIL post_reset_idle: tick=%0b running=%0b expected 0/0", tick, running);
            else pass_cnt++;
        end
        btn_run = 1'b1;
        repeat (5) @(negedge clk);
        btn_run = 1'b0;
        total_cnt++;
        if (running !== 1'b1) $display("FAIL rerun: running=%0b expected 1", running);
        else pass_cnt++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total_cnt++;
            if (tick !== 1'b0) $display("FAIL rerun_gap: tick=%0b expected 0", tick);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (tick !== 1'b1 || number !== 4'd1)
            $display("FAIL rerun_tick: tick=%0b number=%0d expected 1/1", tick, number);
        else pass_cnt++;
        $display("reset mid-run: restart number=%0d", number);
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_pause();
        test_bounce();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
